// File: rtl/rosc_pkg.sv
// ============================================================================
// rosc_pkg : shared state encoding and counter sizing for rosc_entropy_array
// Revision : 1.0
// ============================================================================
`default_nettype none

package rosc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } rosc_state_t;

  // Bits needed for a counter holding the values 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rosc_loop.sv
// ============================================================================
// rosc_loop : one free-running inverter ring of LEN stages, with seed/hold control
// Revision  : 1.0
// ============================================================================
`default_nettype none

module rosc_loop #(
  parameter int LEN = 43
) (
  input  logic ctrl,
  input  logic seed,
  output logic d
);

  (* keep = "true", dont_touch = "true" *) logic [LEN-1:0] stage;

  // ctrl=1 freezes the ring in a known pattern; stage 0 carries the inverted seed.
  assign stage[0] = ctrl ? ~seed : ~d;

  for (genvar k = 1; k < LEN; k++) begin : g_stage
    assign stage[k] = ctrl ? seed : ~stage[k-1];
  end

  assign d = stage[LEN-1];

endmodule

`default_nettype wire

// File: rtl/rosc_entropy_array.sv
// ============================================================================
// rosc_entropy_array : multi-ring oscillator entropy source with word packing
//                      and valid/ready output; ROSC_HEALTH_EN adds a
//                      repetition-count health test.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module rosc_entropy_array #(
  parameter int NUM_LOOPS     = 8,
  parameter int LOOP_LEN      = 43,
  parameter int SEED_CYCLES   = 4,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 16,
  parameter int WORD_W        = 32,
  parameter int REP_LIMIT     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LOOPS-1:0] seed,
  output logic [WORD_W-1:0]    rnd_data,
  output logic                 rnd_valid,
  input  logic                 rnd_ready,
  output logic                 dropped,
  output logic                 health_error
);

  import rosc_pkg::*;

  localparam int PH_MAX = (SEED_CYCLES > WARMUP_CYCLES) ? SEED_CYCLES : WARMUP_CYCLES;
  localparam int PH_W   = cnt_w(PH_MAX);
  localparam int DIV_W  = cnt_w(SAMPLE_DIV);
  localparam int BIT_W  = cnt_w(WORD_W + 1);

  rosc_state_t          r_state;
  rosc_state_t          w_state_next;
  logic [PH_W-1:0]      r_phase_cnt;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [WORD_W-1:0]    r_shreg;
  logic [NUM_LOOPS-1:0] w_ring;
  logic [NUM_LOOPS-1:0] w_ring_seed;
  logic [NUM_LOOPS-1:0] r_sync1;
  logic [NUM_LOOPS-1:0] r_sync2;
  logic                 w_ctrl;
  logic                 w_tick;
  logic                 w_raw;
  logic                 w_word_done;
  logic                 w_load;
  logic                 w_health_block;

  for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_loop
    rosc_loop #(
      .LEN (LOOP_LEN)
    ) u_loop (
      .ctrl (w_ctrl),
      .seed (w_ring_seed[i]),
      .d    (w_ring[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ctrl       = 1'b1;
    w_ring_seed  = '0;
    case (r_state)
      IDLE: begin
        w_state_next = SEED;
      end
      SEED: begin
        w_ring_seed = seed;
        if (r_phase_cnt == PH_W'(SEED_CYCLES - 1)) w_state_next = WARMUP;
      end
      WARMUP: begin
        w_ctrl = 1'b0;
        if (r_phase_cnt == PH_W'(WARMUP_CYCLES - 1)) w_state_next = RUN;
      end
      RUN: begin
        w_ctrl = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (!enable) w_state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_phase_cnt <= '0;
    end else if (r_state == SEED || r_state == WARMUP) begin
      r_phase_cnt <= r_phase_cnt + 1'b1;
    end
  end

  // Sample divider only runs in RUN, so it always starts from 0 on entry.
  assign w_tick = (r_state == RUN) && (r_div == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_state != RUN || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_ring;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw       = ^r_sync2;
  assign w_word_done = (r_bit_cnt == BIT_W'(WORD_W));
  assign w_load      = w_word_done && (!rnd_valid || rnd_ready) && !w_health_block;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      dropped   <= 1'b0;
    end else if (!enable) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (w_tick) r_shreg <= {r_shreg[WORD_W-2:0], w_raw};

      // A sample landing on the completion cycle becomes bit 1 of the next word.
      if (w_word_done) begin
        r_bit_cnt <= w_tick ? BIT_W'(1) : '0;
      end else if (w_tick) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_load) begin
        rnd_data  <= r_shreg;
        rnd_valid <= 1'b1;
      end else if (rnd_valid && rnd_ready) begin
        rnd_valid <= 1'b0;
      end

      if (w_word_done && !w_load && !w_health_block) dropped <= 1'b1;
    end
  end

`ifdef ROSC_HEALTH_EN
  localparam int REP_W = cnt_w(REP_LIMIT + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_prev_raw;
  logic             r_have_prev;
  logic             r_health;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_prev_raw  <= 1'b0;
      r_have_prev <= 1'b0;
      r_health    <= 1'b0;
    end else if (!enable) begin
      r_rep_cnt   <= '0;
      r_prev_raw  <= 1'b0;
      r_have_prev <= 1'b0;
      r_health    <= 1'b0;
    end else if (w_tick) begin
      r_prev_raw  <= w_raw;
      r_have_prev <= 1'b1;
      if (r_have_prev && (w_raw == r_prev_raw)) begin
        if (r_rep_cnt < REP_W'(REP_LIMIT)) r_rep_cnt <= r_rep_cnt + 1'b1;
        if (r_rep_cnt == REP_W'(REP_LIMIT - 1)) r_health <= 1'b1;
      end else begin
        r_rep_cnt <= REP_W'(1);
      end
    end
  end

  assign health_error   = r_health;
  assign w_health_block = r_health;
`else
  // REP_LIMIT only has meaning when the health test is built in.
  assign health_error   = 1'b0 & (REP_LIMIT > 0);
  assign w_health_block = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rosc_entropy_array.sv
// ============================================================================
// tb_rosc_entropy_array : directed self-checking bench with forced ring outputs
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_rosc_entropy_array;

  import rosc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] seed = 4'b1010;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready = 1'b0;
  logic       dropped;
  logic       health_error;

  logic [3:0] ring_pat = 4'b0000;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rosc_entropy_array #(
    .NUM_LOOPS     (4),
    .LOOP_LEN      (43),
    .SEED_CYCLES   (4),
    .WARMUP_CYCLES (16),
    .SAMPLE_DIV    (2),
    .WORD_W        (8),
    .REP_LIMIT     (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .seed         (seed),
    .rnd_data     (rnd_data),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .dropped      (dropped),
    .health_error (health_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    rnd_ready = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Called just after a clock edge: that edge is cycle 0.
  task automatic start_run();
    enable = 1'b1;
    cyc    = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({rnd_valid, dropped, health_error, rnd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%b h=%b data=%h required all 0",
               rnd_valid, dropped, health_error, rnd_data);
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dut.r_state, IDLE);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_startup();
    do_reset();
    ring_pat  = 4'b0001;
    rnd_ready = 1'b0;
    start_run();
    run_to(37);
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL startup_early: valid got %b at cycle 37 required 0", rnd_valid);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL startup_first: got v=%b data=%h required v=1 data=ff", rnd_valid, rnd_data);
    end
  endtask

  // Continues from test_startup: first word ff is held while later words are dropped.
  task automatic test_backpressure();
    bit hold_ok = 1'b1;
    ring_pat = 4'b0000;
    while (cyc < 78) begin
      tick();
      if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) hold_ok = 1'b0;
      if (cyc == 53) begin
        checks++;
        if (dropped !== 1'b0) begin
          errors++;
          $display("FAIL bp_dropped_early: got %b required 0", dropped);
        end
      end
      if (cyc == 54) begin
        checks++;
        if (dropped !== 1'b1) begin
          errors++;
          $display("FAIL bp_dropped_set: got %b required 1", dropped);
        end
      end
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL bp_hold: word not held stable, last v=%b data=%h required v=1 data=ff",
               rnd_valid, rnd_data);
    end
    rnd_ready = 1'b1;
    checks++;
    if (rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL bp_deliver: got %h required ff", rnd_data);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: valid got %b required 0", rnd_valid);
    end
    run_to(86);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h00 || dropped !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_word: got v=%b data=%h d=%b required v=1 data=00 d=1",
               rnd_valid, rnd_data, dropped);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ring_pat  = 4'b0001;
    rnd_ready = 1'b0;
    start_run();
    run_to(38);
    ring_pat = 4'b0000;
    run_to(53);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_pre: got v=%b data=%h required v=1 data=ff", rnd_valid, rnd_data);
    end
    rnd_ready = 1'b1;
    tick();
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h80 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handover: got v=%b data=%h d=%b required v=1 data=80 d=0",
               rnd_valid, rnd_data, dropped);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid got %b required 0", rnd_valid);
    end
  endtask

  task automatic test_bit_order();
    logic [7:0] seq = 8'hB2;
    do_reset();
    rnd_ready = 1'b1;
    start_run();
    run_to(20);
    for (int k = 0; k < 8; k++) begin
      ring_pat = seq[7-k] ? 4'b0111 : 4'b0000;
      tick();
      tick();
    end
    run_to(37);
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_early: valid got %b required 0", rnd_valid);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hB2) begin
      errors++;
      $display("FAIL order_word: got v=%b data=%h required v=1 data=b2", rnd_valid, rnd_data);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_consume: valid got %b required 0", rnd_valid);
    end
  endtask

  task automatic test_abort();
    do_reset();
    ring_pat  = 4'b0001;
    rnd_ready = 1'b0;
    start_run();
    run_to(40);
    checks++;
    if (rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: valid got %b required 1", rnd_valid);
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({rnd_valid, dropped, health_error, rnd_data} !== 11'd0 || dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL abort_clear: got v=%b d=%b h=%b data=%h state=%0d required all 0 state=0",
               rnd_valid, dropped, health_error, rnd_data, dut.r_state);
    end
    start_run();
    run_to(37);
    checks++;
    if (rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_rerun_early: valid got %b required 0", rnd_valid);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin
      errors++;
      $display("FAIL abort_rerun: got v=%b data=%h required v=1 data=ff", rnd_valid, rnd_data);
    end
  endtask

  task automatic test_reset_async();
    do_reset();
    ring_pat  = 4'b0001;
    rnd_ready = 1'b0;
    start_run();
    run_to(10);
    checks++;
    if (dut.r_state !== WARMUP) begin
      errors++;
      $display("FAIL async_pre_state: got %0d required %0d", dut.r_state, WARMUP);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL async_warmup: state got %0d required %0d", dut.r_state, IDLE);
    end
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start_run();
    run_to(56);
    checks++;
    if (rnd_valid !== 1'b1 || dropped !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_out: got v=%b d=%b required v=1 d=1", rnd_valid, dropped);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rnd_valid, dropped, health_error, rnd_data} !== 11'd0) begin
      errors++;
      $display("FAIL async_outputs: got v=%b d=%b h=%b data=%h required all 0",
               rnd_valid, dropped, health_error, rnd_data);
    end
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_health();
    do_reset();
    ring_pat  = 4'b0000;
    rnd_ready = 1'b1;
    start_run();
`ifdef ROSC_HEALTH_EN
    begin
      bit seen = 1'b0;
      run_to(148);
      checks++;
      if (health_error !== 1'b0) begin
        errors++;
        $display("FAIL health_early: got %b required 0", health_error);
      end
      tick();
      checks++;
      if (health_error !== 1'b1) begin
        errors++;
        $display("FAIL health_set: got %b required 1", health_error);
      end
      repeat (40) begin
        tick();
        if (rnd_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || dropped !== 1'b0) begin
        errors++;
        $display("FAIL health_block: valid seen=%b dropped=%b required 0 0", seen, dropped);
      end
    end
`else
    run_to(149);
    checks++;
    if (health_error !== 1'b0) begin
      errors++;
      $display("FAIL health_off: got %b required 0", health_error);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h00) begin
      errors++;
      $display("FAIL health_off_word: got v=%b data=%h required v=1 data=00", rnd_valid, rnd_data);
    end
`endif
  endtask

  initial begin
    force dut.g_loop[0].u_loop.d = ring_pat[0];
    force dut.g_loop[1].u_loop.d = ring_pat[1];
    force dut.g_loop[2].u_loop.d = ring_pat[2];
    force dut.g_loop[3].u_loop.d = ring_pat[3];
    test_reset();
    test_startup();
    test_backpressure();
    test_back_to_back();
    test_bit_order();
    test_abort();
    test_reset_async();
    test_health();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rosc_entropy_array.md
# rosc_entropy_array

Parametrised ring-oscillator entropy source: NUM_LOOPS free-running inverter rings of configurable odd length, seeded, warmed up, then periodically sampled. Samples are synchronised, XOR-combined into one raw bit per sample tick and packed into WORD_W-bit words. Words are delivered over a valid/ready handshake to the downstream conditioning logic. It is the multi-channel, controlled successor to the single fixed 43-stage loop.

## Interface
- NUM_LOOPS, 8: number of independent rings (1..32).
- LOOP_LEN, 43: inverter stages per ring; odd, at least 3.
- SEED_CYCLES, 4: cycles the rings are held in seed mode.
- WARMUP_CYCLES, 256: free-run cycles before the first sample.
- SAMPLE_DIV, 16: clock cycles between samples (at least 1).
- WORD_W, 32: output word width (8..64).
- REP_LIMIT, 64: repetition-count threshold; used only with ROSC_HEALTH_EN.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 runs the source, 0 returns it to IDLE.
- seed  in  NUM_LOOPS  per-ring seed value applied in SEED state.
- rnd_data  out  WORD_W  output word, stable while rnd_valid is 1.
- rnd_valid  out  1  word available.
- rnd_ready  in  1  consumer accepts the word when rnd_valid and rnd_ready are both 1.
- dropped  out  1  sticky; a completed word was discarded because the buffer was full.
- health_error  out  1  sticky repetition-count failure.

## Operation
- States are IDLE, SEED, WARMUP and RUN. Reset enters IDLE, clears all counters, the shift register and the buffer, and drives every output to 0.
- IDLE: ring ctrl=1 with seed 0, so the rings are frozen. When enable=1, go to SEED.
- SEED: ctrl=1 and ring i is driven with seed[i]. Stage 0 receives ~seed[i] and all other stages receive seed[i]. After SEED_CYCLES cycles, go to WARMUP.
- WARMUP: ctrl=0 and the rings oscillate. After WARMUP_CYCLES cycles, go to RUN and clear the sample divider.
- RUN: the divider counts 0..SAMPLE_DIV-1.
  - On wrap, raw = XOR of all synchronised ring outputs.
  - raw shifts into the LSB of the shift register and the bit count increments.
  - When the bit count reaches WORD_W:
    - If the buffer is empty, or is being emptied in the same cycle, load rnd_data and set rnd_valid.
    - Otherwise discard the word and set dropped.
    - In both cases clear the bit count.
- enable=0 in any state: return to IDLE next cycle.
  - rnd_valid, the shift register and the bit count are cleared.
  - dropped and health_error are cleared too. They remain sticky only while enable stays 1.
- Handshake:
  - rnd_valid stays 1 and rnd_data stays stable until the cycle with rnd_valid and rnd_ready both 1.
  - rnd_ready has no effect when rnd_valid=0.

## Timing
- Each ring output passes through a 2-flop synchroniser per ring before the XOR. A sample therefore reflects the ring state 2 cycles earlier.
- From enable rising to the first sample tick: 1 (IDLE→SEED) + SEED_CYCLES + WARMUP_CYCLES + SAMPLE_DIV cycles.
- First rnd_valid: 1 cycle after the WORD_W-th sample tick.
- Steady-state throughput: one word per WORD_W×SAMPLE_DIV cycles. A consumer holding rnd_ready=1 never causes a drop.
- Handover is zero-bubble: accept and reload may occur in the same cycle, and rnd_valid stays 1.

## Configuration
- ROSC_HEALTH_EN defined:
  - A repetition counter compares each raw bit with the previous one.
  - REP_LIMIT identical consecutive raw bits sets health_error.
  - While health_error=1, completed words are discarded (dropped is not set) and rnd_valid is not raised.
  - Clearing requires enable=0 or reset.
- ROSC_HEALTH_EN undefined: health_error is tied to 0, the counter is absent and REP_LIMIT is ignored.

## Structure
- Package rosc_pkg holds the state enum typedef (IDLE, SEED, WARMUP, RUN) and the counter-width helper, a clog2-based function.
- One sub-module, rosc_loop (parameter LEN; ports ctrl, seed, d), is the generalised single ring. It is instantiated NUM_LOOPS times with keep/dont-touch attributes on every stage.
- The top level holds the FSM, counters, synchronisers, shift register and output buffer.

## Test plan
All scenarios use NUM_LOOPS=4, SEED_CYCLES=4, WARMUP_CYCLES=16, SAMPLE_DIV=2 and WORD_W=8. The bench forces the rosc_loop d outputs.

- Startup latency: enable↑ at cycle 0 with forced loop pattern 4'b0001 (raw=1) → rnd_valid first rises at cycle 1+4+16+2×8+1=38 with rnd_data=8'hFF.
- Bit order: drive raw sequence 1,0,1,1,0,0,1,0 with rnd_ready=1 → rnd_data=8'hB2.
- Backpressure: rnd_ready=0 for 40 cycles after the first valid → rnd_data holds its value, dropped=1 after the second completed word, and the first word is delivered intact when rnd_ready=1.
- Abort: enable=0 mid-RUN while rnd_valid=1 → next cycle all outputs are 0 and the state is IDLE. Re-enable repeats the 38-cycle latency.
- Reset mid-WARMUP: assert reset asynchronously → outputs go to 0 immediately, without waiting for a clock edge.
- Health (ROSC_HEALTH_EN, REP_LIMIT=64): hold raw=0 constantly → health_error=1 after the 64th identical sample, and no further rnd_valid.
